// File: rtl/vector_alu.sv
// 64-bit SIMD vector ALU: element-wise ops at 8/16/32/64-bit widths with a single registered result stage.
// Port vectors are MSB-first ([0:63]); internally values are handled numerically, so element 0 is the top slice.
module vector_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:63] rA_64bit_val,
    input  logic [0:63] rB_64bit_val,
    input  logic [0:5]  R_ins,
    input  logic [0:5]  Op_code,
    input  logic [0:1]  WW,
    output logic [0:63] ALU_out
);
    localparam logic [5:0] OPC_VEC = 6'b101010;

    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [3:0][63:0] w_add, w_sub, w_sll, w_srl, w_sra, w_rtth;
    logic [3:0][63:0] w_div, w_mod, w_sqrt, w_mule, w_mulo, w_sqe, w_sqo;
    logic [63:0] w_alu_next;
    logic [63:0] r_alu_out;

    assign w_a = rA_64bit_val;
    assign w_b = rB_64bit_val;

    // Non-restoring-free digit-by-digit square root; no multipliers needed.
    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [63:0] op;
        logic [63:0] res;
        logic [63:0] one;
        op  = v;
        res = '0;
        one = 64'h4000_0000_0000_0000;
        for (int i = 0; i < 32; i++) begin
            if (op >= res + one) begin
                op  = op - (res + one);
                res = (res >> 1) + one;
            end else begin
                res = res >> 1;
            end
            one = one >> 2;
        end
        return res[31:0];
    endfunction

    genvar gk, gi;
    generate
        for (gk = 0; gk < 4; gk++) begin : g_width
            localparam int W  = 8 << gk;
            localparam int N  = 64 / W;
            localparam int SW = $clog2(W);

            for (gi = 0; gi < N; gi++) begin : g_lane
                localparam int HI = 63 - gi * W;
                logic [W-1:0]  w_ae, w_be;
                logic [SW-1:0] w_sh;

                assign w_ae = w_a[HI -: W];
                assign w_be = w_b[HI -: W];
                assign w_sh = w_be[SW-1:0];

                assign w_add[gk][HI -: W]  = w_ae + w_be;
                assign w_sub[gk][HI -: W]  = w_ae - w_be;
                assign w_sll[gk][HI -: W]  = w_ae << w_sh;
                assign w_srl[gk][HI -: W]  = w_ae >> w_sh;
                assign w_sra[gk][HI -: W]  = W'($signed(w_ae) >>> w_sh);
                assign w_rtth[gk][HI -: W] = {w_ae[W/2-1:0], w_ae[W-1:W/2]};
                assign w_div[gk][HI -: W]  = (w_be == '0) ? '0 : w_ae / w_be;
                assign w_mod[gk][HI -: W]  = (w_be == '0) ? '0 : w_ae % w_be;
                assign w_sqrt[gk][HI -: W] = W'(isqrt(64'(w_ae)));
            end

            if (gk < 3) begin : g_pairs
                // Each even/odd pair shares one double-width product slot.
                for (gi = 0; gi < N / 2; gi++) begin : g_pair
                    localparam int HI = 63 - 2 * gi * W;
                    logic [2*W-1:0] w_ae, w_ao, w_be, w_bo;

                    assign w_ae = {{W{1'b0}}, w_a[HI -: W]};
                    assign w_ao = {{W{1'b0}}, w_a[HI-W -: W]};
                    assign w_be = {{W{1'b0}}, w_b[HI -: W]};
                    assign w_bo = {{W{1'b0}}, w_b[HI-W -: W]};

                    assign w_mule[gk][HI -: 2*W] = w_ae * w_be;
                    assign w_mulo[gk][HI -: 2*W] = w_ao * w_bo;
                    assign w_sqe[gk][HI -: 2*W]  = w_ae * w_ae;
                    assign w_sqo[gk][HI -: 2*W]  = w_ao * w_ao;
                end
            end else begin : g_no_pairs
                assign w_mule[gk] = '0;
                assign w_mulo[gk] = '0;
                assign w_sqe[gk]  = '0;
                assign w_sqo[gk]  = '0;
            end
        end
    endgenerate

    always_comb begin
        w_alu_next = '0;
        if (Op_code == OPC_VEC) begin
            case (R_ins)
                6'b000001: w_alu_next = w_a & w_b;
                6'b000010: w_alu_next = w_a | w_b;
                6'b000011: w_alu_next = w_a ^ w_b;
                6'b000100: w_alu_next = ~w_a;
                6'b000101: w_alu_next = w_a;
                6'b000110: w_alu_next = w_add[WW];
                6'b000111: w_alu_next = w_sub[WW];
                6'b001000: w_alu_next = w_mule[WW];
                6'b001001: w_alu_next = w_mulo[WW];
                6'b001010: w_alu_next = w_sll[WW];
                6'b001011: w_alu_next = w_srl[WW];
                6'b001100: w_alu_next = w_sra[WW];
                6'b001101: w_alu_next = w_rtth[WW];
                6'b001110: w_alu_next = w_div[WW];
                6'b001111: w_alu_next = w_mod[WW];
                6'b010000: w_alu_next = w_sqe[WW];
                6'b010001: w_alu_next = w_sqo[WW];
                6'b010010: w_alu_next = w_sqrt[WW];
                default:   w_alu_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_out <= '0;
        end else begin
            r_alu_out <= w_alu_next;
        end
    end

    assign ALU_out = r_alu_out;
endmodule

// File: tb/tb_vector_alu.sv
// Directed-vector bench for vector_alu: table of hand-computed results plus latency and reset sequences.
module tb_vector_alu;
    logic        clk;
    logic        reset;
    logic [0:63] rA_64bit_val;
    logic [0:63] rB_64bit_val;
    logic [0:5]  R_ins;
    logic [0:5]  Op_code;
    logic [0:1]  WW;
    logic [0:63] ALU_out;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] OPV = 6'b101010;

    typedef struct {
        string       name;
        logic [5:0]  opc;
        logic [5:0]  rins;
        logic [1:0]  ww;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    vector_alu dut (
        .clk          (clk),
        .reset        (reset),
        .rA_64bit_val (rA_64bit_val),
        .rB_64bit_val (rB_64bit_val),
        .R_ins        (R_ins),
        .Op_code      (Op_code),
        .WW           (WW),
        .ALU_out      (ALU_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %016h want %016h", nm, act, exp);
        end else begin
            $display("ok   %s: %016h", nm, act);
        end
    endtask

    task automatic drive(input logic [5:0] opc, input logic [5:0] rins, input logic [1:0] ww,
                         input logic [63:0] a, input logic [63:0] b);
        Op_code      = opc;
        R_ins        = rins;
        WW           = ww;
        rA_64bit_val = a;
        rB_64bit_val = b;
    endtask

    task automatic add_vec(input string nm, input logic [5:0] opc, input logic [5:0] rins,
                           input logic [1:0] ww, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp);
        vec_t v;
        v.name = nm; v.opc = opc; v.rins = rins; v.ww = ww;
        v.a = a; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec("vand",      OPV, 6'o01, 2'b10, 64'd15, 64'd14, 64'd14);
        add_vec("vor",       OPV, 6'o02, 2'b10, 64'd15, 64'd14, 64'd15);
        add_vec("vxor",      OPV, 6'o03, 2'b10, 64'd15, 64'd14, 64'd1);
        add_vec("vnot",      OPV, 6'o04, 2'b10, 64'd0, 64'd7, 64'hFFFFFFFF_FFFFFFFF);
        add_vec("vmov",      OPV, 6'o05, 2'b10, 64'hFFFFFFFF_00000000, 64'd3, 64'hFFFFFFFF_00000000);
        add_vec("vadd_b",    OPV, 6'o06, 2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'hFFFFFFFF_10101010);
        add_vec("vadd_w",    OPV, 6'o06, 2'b10, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'hFFFFFFFF_11111110);
        add_vec("vadd_d",    OPV, 6'o06, 2'b11, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 64'h00000000_11111110);
        add_vec("vsub_w",    OPV, 6'o07, 2'b10, 64'hFFFFFFFF_FFFFFFFF, 64'h0F0F0F0F_11111111, 64'hF0F0F0F0_EEEEEEEE);
        add_vec("vmuleu_h",  OPV, 6'o10, 2'b01, 64'hFF000000_FFFFFFFF, 64'h00020000_000F0001, 64'h0001FE00_000EFFF1);
        add_vec("vmulou_w",  OPV, 6'o11, 2'b10, 64'd20, 64'd20, 64'h190);
        add_vec("vmuleu_d",  OPV, 6'o10, 2'b11, 64'd20, 64'd20, 64'd0);
        add_vec("vsqeu_w",   OPV, 6'o20, 2'b10, 64'h00000040_00000001, 64'd9, 64'h00000000_00001000);
        add_vec("vsqou_w",   OPV, 6'o21, 2'b10, 64'h00000040_00000001, 64'd9, 64'd1);
        add_vec("vdiv_b",    OPV, 6'o16, 2'b00, 64'hFF00FF00_FF00FF00, 64'h11221122_44444444, 64'h0F000F00_03000300);
        add_vec("vmod_d",    OPV, 6'o17, 2'b11, 64'd102, 64'd10, 64'd2);
        add_vec("vdiv_zero", OPV, 6'o16, 2'b10, 64'h12345678_9ABCDEF0, 64'd0, 64'd0);
        add_vec("vmod_zero", OPV, 6'o17, 2'b00, 64'h12345678_9ABCDEF0, 64'd0, 64'd0);
        add_vec("vsqrt_b",   OPV, 6'o22, 2'b00, 64'hFF01FFFF_10040001, 64'd5, 64'h0F010F0F_04020001);
        add_vec("vsqrt_h",   OPV, 6'o22, 2'b01, 64'h00000640_00040001, 64'd5, 64'h00000028_00020001);
        add_vec("vrtth_d",   OPV, 6'o15, 2'b11, 64'hFFFFFFFF_00000000, 64'd5, 64'h00000000_FFFFFFFF);
        add_vec("vsll_d",    OPV, 6'o12, 2'b11, 64'hF0E1F2A2_01010101, 64'hA, 64'h87CA8804_04040400);
        add_vec("vsrl_d",    OPV, 6'o13, 2'b11, 64'hF0E1F2A2_01010101, 64'hA, 64'h003C387C_A8804040);
        add_vec("vsra_b",    OPV, 6'o14, 2'b00, 64'hF0E1F2A2_01010101, 64'h02020202_02020202, 64'hFCF8FCE8_00000000);
        add_vec("bad_opc",   6'b000000, 6'o02, 2'b10, 64'hFF, 64'hFF, 64'd0);
        add_vec("bad_rins",  OPV, 6'b111111, 2'b10, 64'hFF, 64'hFF, 64'd0);

        reset = 1'b1;
        drive(OPV, 6'o02, 2'b10, 64'hFF, 64'hFF);
        @(posedge clk); #1;
        chk("reset", ALU_out, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].opc, vecs[i].rins, vecs[i].ww, vecs[i].a, vecs[i].b);
            @(posedge clk); #1;
            chk(vecs[i].name, ALU_out, vecs[i].exp);
        end

        // Latency: the new result must not appear before the next edge.
        @(negedge clk);
        drive(OPV, 6'o01, 2'b10, 64'd15, 64'd14);
        @(posedge clk); #1;
        chk("lat_and", ALU_out, 64'd14);
        @(negedge clk);
        drive(OPV, 6'o03, 2'b10, 64'd15, 64'd14);
        #1;
        chk("lat_hold", ALU_out, 64'd14);
        @(posedge clk); #1;
        chk("lat_xor", ALU_out, 64'd1);

        // Reset mid-stream wins over a valid op, then results resume.
        @(negedge clk);
        reset = 1'b1;
        drive(OPV, 6'o02, 2'b10, 64'd15, 64'd14);
        @(posedge clk); #1;
        chk("mid_reset", ALU_out, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset", ALU_out, 64'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vector_alu.md
Name: vector_alu

Overview:
- 64-bit SIMD vector ALU for the phase-2 datapath (execute stage).
- Operates element-wise on two 64-bit operands at 8/16/32/64-bit element width (WW).
- Produces a registered 64-bit result one clock after the operands are presented.
- Bit numbering is big-endian throughout: bit 0 is the MSB, and element 0 is the most significant element.

Parameters:
- None. Datapath width is fixed at 64.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rA_64bit_val  input  [0:63]  operand A.
- rB_64bit_val  input  [0:63]  operand B.
- R_ins  input  [0:5]  function code.
- Op_code  input  [0:5]  primary opcode; only 6'b101010 (R-type vector) executes.
- WW  input  [0:1]  element width: 00=8, 01=16, 10=32, 11=64 bits.
- ALU_out  output  [0:63]  registered result.

Behaviour:
- Timing: on each rising clk, ALU_out <= f(current inputs). Latency is 1 cycle; no handshake; a new operation is accepted every cycle.
- Reset: when reset=1 at a clock edge, ALU_out <= 0. Reset has priority over any operation.
- Invalid codes: if Op_code != 101010, or R_ins is not listed below, ALU_out <= 0.
- All arithmetic is unsigned modulo the element width, except VSRA. There are no carries between elements.
- R_ins function codes:
  - 000001 VAND: rA & rB. WW ignored.
  - 000010 VOR: rA | rB. WW ignored.
  - 000011 VXOR: rA ^ rB. WW ignored.
  - 000100 VNOT: ~rA. WW ignored.
  - 000101 VMOV: rA. WW ignored.
  - 000110 VADD: per element rA+rB, wrapping.
  - 000111 VSUB: per element rA-rB, wrapping.
  - 001000 VMULEU: multiply even-indexed elements (0,2,..). Each 2w-bit product occupies the double-width slot covering elements i and i+1.
  - 001001 VMULOU: same as VMULEU using odd-indexed elements.
  - 001010 VSLL: per element, rA element shifted left logically.
  - 001011 VSRL: per element, rA element shifted right logically.
  - 001100 VSRA: per element, rA element shifted right arithmetically (sign-filled).
  - Shift amount for VSLL/VSRL/VSRA = low log2(w) bits (LSBs) of the corresponding rB element.
  - 001101 VRTTH: per element, swap upper and lower halves (rotate by w/2).
  - 001110 VDIV: per element unsigned rA/rB. Divisor 0 gives element result 0.
  - 001111 VMOD: per element unsigned rA%rB. Divisor 0 gives element result 0.
  - 010000 VSQEU: square even-indexed elements into double-width slots.
  - 010001 VSQOU: square odd-indexed elements into double-width slots.
  - 010010 VSQRT: per element floor(sqrt(unsigned rA)).
- For VMULEU/VMULOU/VSQEU/VSQOU, WW=11 has no double-width slot, so the output is 0.
- rB is ignored by VNOT, VMOV, VRTTH, VSQEU, VSQOU and VSQRT.

Test Plan:
- Reset, logic and move ops (all with WW=10):
  - Hold reset one edge -> ALU_out=0.
  - Then rA=15, rB=14: VAND -> 14; VOR -> 15; VXOR -> 1.
  - VNOT with rA=0 -> FFFFFFFF_FFFFFFFF.
  - VMOV with rA=FFFFFFFF_00000000 -> FFFFFFFF_00000000.
  - Each result appears exactly one edge after the inputs are applied.
- Add/sub per width, rA=FFFFFFFF_FFFFFFFF, rB=00000000_11111111:
  - VADD WW=00 -> FFFFFFFF_10101010.
  - VADD WW=10 -> FFFFFFFF_11111110.
  - VADD WW=11 -> 00000000_11111110.
  - VSUB WW=10 with rB=0F0F0F0F_11111111 -> F0F0F0F0_EEEEEEEE.
- Multiply/square:
  - VMULEU WW=01, rA=FF000000_FFFFFFFF, rB=00020000_000F0001 -> 0001FE00_000EFFF1.
  - VMULOU WW=10, rA=rB=20 -> 400 (0x190).
  - VSQEU WW=10, rA=00000040_00000001 -> 00000000_00001000.
  - VSQOU with the same rA -> 1.
- Div/mod/sqrt/rotate:
  - VDIV WW=00, rA=FF00FF00_FF00FF00, rB=11221122_44444444 -> 0F000F00_03000300.
  - VMOD WW=11, 102 % 10 -> 2.
  - VDIV with rB=0 -> 0.
  - VSQRT WW=00, rA=FF01FFFF_10040001 -> 0F010F0F_04020001.
  - VSQRT WW=01, rA=00000640_00040001 -> 00000028_00020001.
  - VRTTH WW=11, rA=FFFFFFFF_00000000 -> 00000000_FFFFFFFF.
- Shifts, rA=F0E1F2A2_01010101:
  - VSLL WW=11, rB=A -> 87CA8804_04040400.
  - VSRL WW=11, rB=A -> 003C387C_A8804040.
  - VSRA WW=00, rB=02020202_02020202 -> FCF8FCE8_00000000.
- Boundary: Op_code=000000 with any R_ins -> 0; reset asserted mid-stream -> 0 next edge, normal results resume after release.
